// File: rtl/fifo_param.sv
// ============================================================================
// Module   : fifo_param
// Purpose  : Parametrised synchronous FIFO with integrated memory, pointers,
//            occupancy count and threshold flags. Optional sticky
//            overflow/underflow reporting is enabled by defining FIFO_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_param #(
  parameter int WORD_SIZE = 6,
  parameter int MEM_SIZE  = 4,
  parameter int PTR_L     = 2,
  parameter int AF_THRESH = 3,
  parameter int AE_THRESH = 1
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 valid_out,
  output logic [PTR_L:0]       fifo_count,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 fifo_error
);

  localparam logic [PTR_L:0] FULL_CNT = (PTR_L+1)'(MEM_SIZE);
  localparam logic [PTR_L:0] AF_CNT   = (PTR_L+1)'(AF_THRESH);
  localparam logic [PTR_L:0] AE_CNT   = (PTR_L+1)'(AE_THRESH);

  logic [WORD_SIZE-1:0] mem [MEM_SIZE];
  logic [PTR_L-1:0]     wr_ptr;
  logic [PTR_L-1:0]     rd_ptr;
  logic [PTR_L:0]       count;
  logic                 pop_ok;
  logic                 push_ok;

  // A push into a full FIFO is still legal when a pop frees a slot this cycle.
  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != FULL_CNT) || pop_ok);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      for (int i = 0; i < MEM_SIZE; i++) begin
        mem[i] <= '0;
      end
    end else begin
      valid_out <= pop_ok;
      if (pop_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      if (push_ok) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_ERR_EN
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      fifo_error <= 1'b0;
    end else if ((push && !push_ok) || (pop && !pop_ok)) begin
      fifo_error <= 1'b1;
    end
  end
`else
  assign fifo_error = 1'b0;
`endif

  assign fifo_count   = count;
  assign fifo_full    = (count == FULL_CNT);
  assign fifo_empty   = (count == '0);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

endmodule

`default_nettype wire

// File: tb/tb_fifo_param.sv
// ============================================================================
// Module   : tb_fifo_param
// Purpose  : Self-checking bench for fifo_param: directed vector table,
//            asynchronous-reset sequence and randomized queue-model checking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_param;

  localparam int W     = 6;
  localparam int DEPTH = 4;
  localparam int PL    = 2;
  localparam int AF    = 3;
  localparam int AE    = 1;
`ifdef FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk;
  logic          reset_L;
  logic          push;
  logic          pop;
  logic [W-1:0]  data_in;
  logic [W-1:0]  data_out;
  logic          valid_out;
  logic [PL:0]   fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          almost_full;
  logic          almost_empty;
  logic          fifo_error;

  fifo_param #(
    .WORD_SIZE(W), .MEM_SIZE(DEPTH), .PTR_L(PL), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk(clk), .reset_L(reset_L), .push(push), .pop(pop), .data_in(data_in),
    .data_out(data_out), .valid_out(valid_out), .fifo_count(fifo_count),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .fifo_error(fifo_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         p;
    logic         q;
    logic [W-1:0] din;
    logic [PL:0]  cnt;
    logic [W-1:0] dout;
    logic         valid;
    logic         err;   // error expected when the error build is enabled
  } vec_t;

  vec_t         tbl[$];
  int           vectors = 0;
  int           miscompares = 0;

  // Reference model state
  logic [W-1:0] mq[$];
  logic [W-1:0] m_dout;
  logic         m_valid;
  logic         m_err;

  task automatic add(input logic p, input logic q, input logic [W-1:0] d,
                     input int c, input logic [W-1:0] o, input logic v, input logic e);
    vec_t t;
    t.p = p; t.q = q; t.din = d; t.cnt = (PL+1)'(c); t.dout = o; t.valid = v; t.err = e;
    tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int c, input logic [W-1:0] o,
                           input logic v, input logic e);
    chk({tag, ".count"},        32'(fifo_count),   32'(c));
    chk({tag, ".data_out"},     32'(data_out),     32'(o));
    chk({tag, ".valid_out"},    32'(valid_out),    32'(v));
    chk({tag, ".fifo_full"},    32'(fifo_full),    32'(c == DEPTH));
    chk({tag, ".fifo_empty"},   32'(fifo_empty),   32'(c == 0));
    chk({tag, ".almost_full"},  32'(almost_full),  32'(c >= AF));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(c <= AE));
    chk({tag, ".fifo_error"},   32'(fifo_error),   32'(e & ERR_EN));
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout = '0; m_valid = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step(input logic p, input logic q, input logic [W-1:0] d);
    bit pop_acc, push_acc;
    pop_acc  = q && (mq.size() > 0);
    push_acc = p && ((mq.size() < DEPTH) || pop_acc);
    m_valid  = pop_acc;
    if (pop_acc) m_dout = mq.pop_front();
    if (push_acc) mq.push_back(d);
    if ((p && !push_acc) || (q && !pop_acc)) m_err = 1'b1;
  endtask

  task automatic cycle(input logic p, input logic q, input logic [W-1:0] d);
    push = p; pop = q; data_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_L = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;

    // Directed vectors: {push, pop, data_in} -> {count, data_out, valid, error}
    add(0,0,6'h00, 0,6'h00,0,0);
    add(0,0,6'h00, 0,6'h00,0,0);
    add(1,0,6'h01, 1,6'h00,0,0);
    add(1,0,6'h02, 2,6'h00,0,0);
    add(1,0,6'h03, 3,6'h00,0,0);
    add(1,0,6'h04, 4,6'h00,0,0);
    add(1,0,6'h3F, 4,6'h00,0,1);   // overflow rejected
    add(0,1,6'h00, 3,6'h01,1,1);
    add(0,1,6'h00, 2,6'h02,1,1);
    add(0,1,6'h00, 1,6'h03,1,1);
    add(0,1,6'h00, 0,6'h04,1,1);
    add(0,1,6'h00, 0,6'h04,0,1);   // underflow, data_out holds
    add(1,0,6'h0A, 1,6'h04,0,1);
    add(1,0,6'h0B, 2,6'h04,0,1);
    add(1,0,6'h0C, 3,6'h04,0,1);
    add(1,0,6'h0D, 4,6'h04,0,1);
    add(1,1,6'h2A, 4,6'h0A,1,1);   // push+pop while full
    add(0,1,6'h00, 3,6'h0B,1,1);
    add(0,1,6'h00, 2,6'h0C,1,1);
    add(0,1,6'h00, 1,6'h0D,1,1);
    add(0,1,6'h00, 0,6'h2A,1,1);   // wrapped word comes out last
    add(1,1,6'h15, 1,6'h2A,0,1);   // push+pop while empty: pop rejected
    add(0,1,6'h00, 0,6'h15,1,1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_L = 1'b1;

    foreach (tbl[i]) begin
      cycle(tbl[i].p, tbl[i].q, tbl[i].din);
      check_all($sformatf("vec%0d", i), int'(tbl[i].cnt), tbl[i].dout,
                tbl[i].valid, tbl[i].err);
    end

    // Asynchronous reset mid-stream: fill to 3 then drop reset between edges
    cycle(0,1,6'h00);                     // drain nothing (already empty)
    cycle(1,0,6'h11);
    cycle(1,0,6'h12);
    cycle(1,0,6'h13);
    check_all("prefill", 3, 6'h15, 0, 1);
    #2 reset_L = 1'b0;
    #1 check_all("async_rst", 0, 6'h00, 0, 0);
    @(posedge clk); #1;
    check_all("rst_hold", 0, 6'h00, 0, 0);
    @(negedge clk);
    reset_L = 1'b1;
    cycle(1,0,6'h07);
    check_all("post_push", 1, 6'h00, 0, 0);
    cycle(0,1,6'h00);
    check_all("post_pop", 0, 6'h07, 1, 0);

    // Randomized traffic against the queue model, from a fresh reset
    reset_L = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    reset_L = 1'b1;
    for (int n = 0; n < 600; n++) begin
      logic p, q;
      logic [W-1:0] d;
      int thr;
      thr = ((n / 40) % 2 == 0) ? 75 : 25;
      p = ($urandom_range(0, 99) < thr);
      q = ($urandom_range(0, 99) < (100 - thr));
      d = W'($urandom);
      model_step(p, q, d);
      cycle(p, q, d);
      check_all($sformatf("rnd%0d", n), mq.size(), m_dout, m_valid, m_err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO that integrates the word memory, the read/write pointers and the flag logic in a single block. Pushes and pops are accepted internally, so no external pointer generation is needed. It is the next generation of the standalone FIFO memory: width, depth and almost-full/almost-empty thresholds are configurable, and it adds occupancy count, simultaneous push/pop while full, and optional overflow/underflow error reporting. It sits between a producer and a consumer in the FIFO datapath.

## Interface
Parameters:
- WORD_SIZE, 6, data width in bits
- MEM_SIZE, 4, depth in words; power of two, ≥2
- PTR_L, 2, pointer width; must equal log2(MEM_SIZE)
- AF_THRESH, 3, almost_full asserts when count ≥ AF_THRESH; range 1..MEM_SIZE
- AE_THRESH, 1, almost_empty asserts when count ≤ AE_THRESH; range 0..MEM_SIZE-1

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- reset_L  input  1  asynchronous, active-low reset
- push  input  1  write request for data_in
- pop  input  1  read request
- data_in  input  WORD_SIZE  write data
- data_out  output  WORD_SIZE  registered read data
- valid_out  output  1  data_out holds a newly popped word this cycle
- fifo_count  output  PTR_L+1  occupancy, 0..MEM_SIZE
- fifo_full  output  1  count == MEM_SIZE
- fifo_empty  output  1  count == 0
- almost_full  output  1  count ≥ AF_THRESH
- almost_empty  output  1  count ≤ AE_THRESH
- fifo_error  output  1  sticky overflow/underflow flag (see Configuration)

## Operation
- Reset (reset_L low, any time, asynchronous):
  - wr_ptr, rd_ptr and count clear to 0.
  - Memory words clear to 0.
  - data_out=0, valid_out=0, fifo_error=0.
  - Resulting flags: fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=0.
  - Any in-flight push or pop in that cycle is discarded.
- Pop acceptance: a pop is accepted iff pop=1 and count≠0.
  - mem[rd_ptr] is registered into data_out.
  - rd_ptr increments.
- Push acceptance: a push is accepted iff push=1 and (count<MEM_SIZE, or a pop is accepted in the same cycle).
  - data_in is written to mem[wr_ptr].
  - wr_ptr increments.
- Pointer wrap: pointers are PTR_L bits and wrap MEM_SIZE-1 → 0 naturally.
- Count update:
  - +1 on push only, −1 on pop only.
  - Unchanged when both are accepted, or when neither is.
- Simultaneous push and pop:
  - When full: both are accepted, count stays MEM_SIZE, and the oldest word is output.
  - When empty: only the push is accepted and the pop is rejected (underflow). Data does not pass through in that cycle.
- Rejected requests change no pointer, memory, count or data_out.
- data_out holds its last value when no pop is accepted; valid_out=0 in that case.
- Flags are combinational decodes of the registered count and add no extra latency.

## Timing
- Pop latency: data_out and valid_out update at the rising edge that accepts the pop, so they are visible for the cycle after pop is sampled.
- valid_out stays high for exactly one cycle per accepted pop. Back-to-back pops give continuous valid_out.
- Write-to-read: a word pushed at edge N can be popped at edge N+1 at the earliest.
- fifo_count and all flags reflect accepted operations from the same edge onward.
- fifo_error sets at the edge sampling the offending request.
- Reset mid-stream:
  - Outputs go to reset values immediately on reset_L falling, without waiting for clk.
  - Operation resumes on the first rising edge after reset_L rises.

## Configuration
- Macro FIFO_ERR_EN.
- Defined:
  - fifo_error sets on a rejected push (push=1, full, no accepted pop) or a rejected pop (pop=1, count=0).
  - It stays set until reset.
- Undefined:
  - fifo_error is tied to 0.
  - Rejected requests are dropped silently.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then idle 2 cycles → count=0, empty=1, almost_empty=1, full=0, almost_full=0, data_out=0, valid_out=0, fifo_error=0.
- Push 0x01,0x02,0x03,0x04 on consecutive cycles (MEM_SIZE=4) → count 1,2,3,4; almost_full at count 3; full at count 4. A 5th push of 0x3F is rejected, count stays 4, fifo_error=1 (FIFO_ERR_EN) or 0 (undefined).
- From full, pop 4 cycles → data_out 0x01,0x02,0x03,0x04 with valid_out high 4 cycles, then empty=1. A 5th pop gives valid_out=0, data_out holds 0x04, fifo_error=1 with FIFO_ERR_EN.
- Full, then push 0x2A with pop in the same cycle → data_out=oldest word, valid_out=1, count stays 4. Draining then yields 0x2A last, confirming wrap of wr_ptr 3→0.
- Empty, then push 0x15 with pop in the same cycle → count=1, valid_out=0, fifo_error=1 with FIFO_ERR_EN. Next cycle pop → data_out=0x15.
- Fill to 3, then assert reset_L low between clock edges → all outputs reach reset values without a clk edge. After release, a push of 0x07 then a pop returns 0x07.
